// File: rtl/cnn_params_pkg.sv
// Shared image/kernel defaults, FSM encodings and counter-width helpers
// for the convolution window controller.
package cnn_params_pkg;

    localparam int IMG_W_DEF = 28;
    localparam int IMG_H_DEF = 28;
    localparam int K_DEF     = 3;

    localparam logic [1:0] ST_IDLE_ENC = 2'd0;
    localparam logic [1:0] ST_RUN_ENC  = 2'd1;
    localparam logic [1:0] ST_DONE_ENC = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = ST_IDLE_ENC,
        ST_RUN  = ST_RUN_ENC,
        ST_DONE = ST_DONE_ENC
    } state_t;

    // Counter width for a modulus n; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int COL_W_DEF = cnt_width(IMG_W_DEF);
    localparam int ROW_W_DEF = cnt_width(IMG_H_DEF);

endpackage

// File: rtl/wrap_counter.sv
// Modulo-MOD up-counter with enable and clear; wrap_o flags the enabled
// step from MOD-1 back to 0.
module wrap_counter
    import cnn_params_pkg::*;
#(
    parameter int MOD = 2,
    parameter int W   = cnt_width(MOD)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o,
    output logic         wrap_o
);

    localparam logic [W-1:0] MAX = W'(MOD - 1);

    logic [W-1:0] cnt_q, cnt_d;

    assign wrap_o = en_i && (cnt_q == MAX);
    assign cnt_o  = cnt_q;

    always_comb begin
        // NOTE: default assigned first so no path leaves cnt_d unassigned (no latch).
        cnt_d = cnt_q;
        if (clr_i || wrap_o) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // NOTE: reset is synchronous and active-low, so it lives inside the clocked branch.
    always_ff @(posedge clk) begin
        if (!rst) begin
            // NOTE: non-blocking assignment for all registered state.
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/conv_window_ctrl.sv
// Raster-scan controller for a KxK sliding window over an IMG_W x IMG_H
// frame: accepts pixels, tracks position and flags valid windows.
module conv_window_ctrl
    import cnn_params_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEF,
    parameter int IMG_H = IMG_H_DEF,
    parameter int K     = K_DEF,
    parameter int CW    = cnt_width(IMG_W),
    parameter int RW    = cnt_width(IMG_H)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          din_vld,
    output logic          din_rdy,
    output logic          shift_en,
    output logic          win_vld,
    output logic [RW-1:0] win_row,
    output logic [CW-1:0] win_col,
    output logic          busy,
    output logic          frame_done
);

    localparam logic [RW-1:0] K_ROW = RW'(K - 1);
    localparam logic [CW-1:0] K_COL = CW'(K - 1);

    state_t        state_q, state_d;
    logic          accept, clr_cnt, row_en, col_wrap, row_wrap, win_hit;
    logic [CW-1:0] col_cnt;
    logic [RW-1:0] row_cnt;
    logic          win_vld_q;
    logic [RW-1:0] win_row_q, win_row_d;
    logic [CW-1:0] win_col_q, win_col_d;

    assign shift_en = din_vld & din_rdy;
    assign accept   = shift_en;
    assign clr_cnt  = (state_q == ST_IDLE) && start;
    assign row_en   = accept && col_wrap;

    wrap_counter #(.MOD(IMG_W), .W(CW)) u_col_cnt (
        .clk    (clk),
        .rst    (rst),
        .en_i   (accept),
        .clr_i  (clr_cnt),
        .cnt_o  (col_cnt),
        .wrap_o (col_wrap)
    );

    // Row advances only on the column wrap; its own wrap marks the last pixel.
    wrap_counter #(.MOD(IMG_H), .W(RW)) u_row_cnt (
        .clk    (clk),
        .rst    (rst),
        .en_i   (row_en),
        .clr_i  (clr_cnt),
        .cnt_o  (row_cnt),
        .wrap_o (row_wrap)
    );

    always_comb begin
        state_d    = state_q;
        din_rdy    = 1'b0;
        busy       = 1'b0;
        frame_done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_RUN;
            end
            ST_RUN: begin
                din_rdy = 1'b1;
                busy    = 1'b1;
                if (row_wrap) state_d = ST_DONE;
            end
            ST_DONE: begin
                busy       = 1'b1;
                frame_done = 1'b1;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    // A window is complete once the accepted pixel is its bottom-right corner.
    assign win_hit   = accept && (row_cnt >= K_ROW) && (col_cnt >= K_COL);
    assign win_row_d = win_hit ? (row_cnt - K_ROW) : win_row_q;
    assign win_col_d = win_hit ? (col_cnt - K_COL) : win_col_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            win_vld_q <= 1'b0;
            win_row_q <= '0;
            win_col_q <= '0;
        end else begin
            win_vld_q <= win_hit;
            win_row_q <= win_row_d;
            win_col_q <= win_col_d;
        end
    end

    assign win_vld = win_vld_q;
    assign win_row = win_row_q;
    assign win_col = win_col_q;

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Scoreboard bench: the driver pushes expected windows, a negedge monitor
// pops and compares; a second 4x4/K=4 instance covers the single-window case.
module tb_conv_window_ctrl;

    localparam int IMG_W = 28;
    localparam int IMG_H = 28;
    localparam int K     = 3;
    localparam int NWIN  = (IMG_H - K + 1) * (IMG_W - K + 1);   // 676
    localparam int NPIX  = IMG_W * IMG_H;                        // 784

    typedef enum {M_IDLE, M_RUN, M_DONE} mstate_t;
    typedef struct { int r; int c; bit last; } win_t;

    logic       clk = 1'b0;
    logic       rst, start, din_vld;
    logic       din_rdy, shift_en, win_vld, busy, frame_done;
    logic [4:0] win_row, win_col;

    logic       s_start, s_vld, s_rdy, s_shift, s_win_vld, s_busy, s_fd;
    logic [1:0] s_win_row, s_win_col;

    always #5 clk = ~clk;

    conv_window_ctrl #(.IMG_W(IMG_W), .IMG_H(IMG_H), .K(K)) dut (
        .clk(clk), .rst(rst), .start(start), .din_vld(din_vld),
        .din_rdy(din_rdy), .shift_en(shift_en), .win_vld(win_vld),
        .win_row(win_row), .win_col(win_col), .busy(busy),
        .frame_done(frame_done)
    );

    conv_window_ctrl #(.IMG_W(4), .IMG_H(4), .K(4)) dut_s (
        .clk(clk), .rst(rst), .start(s_start), .din_vld(s_vld),
        .din_rdy(s_rdy), .shift_en(s_shift), .win_vld(s_win_vld),
        .win_row(s_win_row), .win_col(s_win_col), .busy(s_busy),
        .frame_done(s_fd)
    );

    int      n_checks = 0;
    int      n_errors = 0;
    win_t    q[$];
    mstate_t m_state = M_IDLE;
    int      m_r = 0, m_c = 0;
    bit      mon_en = 1'b0;
    bit      exp_rdy = 1'b0, exp_busy = 1'b0, exp_fd = 1'b0, exp_shift = 1'b0;
    int      hold_row = 0, hold_col = 0;
    int      win_cnt = 0, shift_cnt = 0, fd_cnt = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; the model predicts this cycle's outputs and the
    // window (if any) that must appear in the next cycle.
    task automatic cycle(input logic s, input logic v);
        bit   acc, has_win, last;
        win_t w;
        start     = s;
        din_vld   = v;
        exp_rdy   = (m_state == M_RUN);
        exp_busy  = (m_state != M_IDLE);
        exp_fd    = (m_state == M_DONE);
        acc       = v && (m_state == M_RUN);
        exp_shift = acc;
        has_win   = 1'b0;
        last      = 1'b0;
        w         = '{0, 0, 1'b0};
        case (m_state)
            M_IDLE: if (s) begin m_state = M_RUN; m_r = 0; m_c = 0; end
            M_RUN: if (acc) begin
                has_win = (m_r >= K - 1) && (m_c >= K - 1);
                last    = (m_r == IMG_H - 1) && (m_c == IMG_W - 1);
                w       = '{m_r - (K - 1), m_c - (K - 1), last};
                if (m_c == IMG_W - 1) begin
                    m_c = 0;
                    m_r = (m_r == IMG_H - 1) ? 0 : m_r + 1;
                end else begin
                    m_c = m_c + 1;
                end
                if (last) m_state = M_DONE;
            end
            default: m_state = M_IDLE;
        endcase
        @(posedge clk);
        if (has_win) q.push_back(w);
        #1;
    endtask

    task automatic do_reset();
        rst     = 1'b0;
        start   = 1'b0;
        din_vld = 1'b0;
        exp_rdy   = (m_state == M_RUN);
        exp_busy  = (m_state != M_IDLE);
        exp_fd    = (m_state == M_DONE);
        exp_shift = 1'b0;
        @(posedge clk);
        m_state = M_IDLE;
        m_r = 0;
        m_c = 0;
        #1;
        rst = 1'b1;
        exp_rdy = 1'b0; exp_busy = 1'b0; exp_fd = 1'b0; exp_shift = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        @(negedge clk);
        check({tag, "_win_vld"},    win_vld,    0);
        check({tag, "_win_row"},    win_row,    0);
        check({tag, "_win_col"},    win_col,    0);
        check({tag, "_frame_done"}, frame_done, 0);
        check({tag, "_busy"},       busy,       0);
        check({tag, "_din_rdy"},    din_rdy,    0);
        check({tag, "_shift_en"},   shift_en,   0);
        @(posedge clk);
        #1;
    endtask

    // Full frame: start in IDLE (din_vld high there too), optional gaps and a
    // stray start at RUN step start_at; start is also pulsed in the DONE cycle.
    task automatic run_frame(input bit gaps, input int start_at, input string tag);
        int wb, sb, fb;
        wb = win_cnt; sb = shift_cnt; fb = fd_cnt;
        cycle(1'b1, 1'b1);
        for (int k = 0; k < 4 * NPIX && m_state != M_DONE; k++)
            cycle(k == start_at, gaps ? (k % 2 == 0) : 1'b1);
        cycle(1'b1, 1'b1);
        repeat (3) cycle(1'b0, 1'b0);
        check({tag, "_windows"},    win_cnt - wb,   NWIN);
        check({tag, "_shifts"},     shift_cnt - sb, NPIX);
        check({tag, "_frame_done"}, fd_cnt - fb,    1);
    endtask

    always @(negedge clk) begin
        win_t e;
        if (mon_en) begin
            check("din_rdy",    din_rdy,    exp_rdy);
            check("busy",       busy,       exp_busy);
            check("frame_done", frame_done, exp_fd);
            check("shift_en",   shift_en,   exp_shift);
            if (shift_en)   shift_cnt++;
            if (frame_done) fd_cnt++;
            if (win_vld)    win_cnt++;
            if (q.size() != 0) begin
                e = q.pop_front();
                check("win_vld", win_vld, 1);
                if (win_vld) begin
                    check("win_row", win_row, e.r);
                    check("win_col", win_col, e.c);
                    check("win_last_done", frame_done, e.last);
                end
                hold_row = e.r;
                hold_col = e.c;
            end else begin
                check("win_vld", win_vld, 0);
                check("win_row_hold", win_row, hold_row);
                check("win_col_hold", win_col, hold_col);
            end
            if (!rst) begin
                hold_row = 0;
                hold_col = 0;
            end
        end
    end

    initial begin
        int fb, s_wins, s_dones;
        rst = 1'b0; start = 1'b0; din_vld = 1'b0;
        s_start = 1'b0; s_vld = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        mon_en = 1'b1;
        check_zero("reset");

        repeat (3) cycle(1'b0, 1'b1);              // din_vld in IDLE is not accepted
        run_frame(1'b0, 100, "cont");              // stray start mid-RUN
        run_frame(1'b1, -1,  "gaps");

        fb = fd_cnt;
        cycle(1'b1, 1'b1);
        repeat (300) cycle(1'b0, 1'b1);
        do_reset();
        check_zero("abort");
        repeat (2) cycle(1'b0, 1'b0);
        check("abort_no_done", fd_cnt - fb, 0);
        run_frame(1'b0, -1, "after_abort");
        mon_en = 1'b0;

        s_wins = 0; s_dones = 0;
        s_start = 1'b1;
        @(posedge clk);
        #1;
        s_start = 1'b0;
        s_vld = 1'b1;
        repeat (20) begin
            @(negedge clk);
            check("small_win_eq_done", s_win_vld, s_fd);
            if (s_win_vld) begin
                s_wins++;
                check("small_win_row", s_win_row, 0);
                check("small_win_col", s_win_col, 0);
            end
            if (s_fd) s_dones++;
        end
        s_vld = 1'b0;
        check("small_windows", s_wins, 1);
        check("small_frame_done", s_dones, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
